decode_issue: RTL and testbench
===============================

# decode_issue

Instruction decode and operand-issue stage placed directly ahead of the ALU. Accepts 32-bit RV64IM arithmetic instructions over a valid/ready handshake, reads operands from an internal 32×64 register file, and produces the 6-bit `alu_control` code, `dataA` and `dataB` in a single output pipeline register. A per-register busy scoreboard stalls issue until writeback returns. Writeback results enter through a dedicated write port.

## Interface
- `BUS_DATA_WIDTH`, default 64: operand and register width.
- `clk` input 1: clock, all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_instr` is valid.
- `in_ready` output 1: instruction accepted on this edge if `in_valid` is also high.
- `in_instr` input 32: RV64IM instruction word.
- `out_valid` output 1: output register holds an issued operation.
- `out_ready` input 1: the ALU consumes the output on this edge.
- `dataA` output BUS_DATA_WIDTH: rs1 value.
- `dataB` output BUS_DATA_WIDTH: rs2 value, or the sign-extended immediate/shamt.
- `alu_control` output 6: operation code.
- `out_rd` output 5: destination register.
- `out_illegal` output 1: instruction not decodable; `alu_control`=0.
- `wb_en` input 1: register file write enable.
- `wb_rd` input 5: write address.
- `wb_data` input BUS_DATA_WIDTH: write data.

## Operation
- Opcode mapping. Any other opcode/funct is illegal.
  - `0010011` (OP-IMM), funct3 0..7: addi=1, slli=7, slti=2, sltiu=3, xori=4, srli=8 / srai=9 (selected by instr[30]), ori=5, andi=6.
  - `0110011` (OP) with funct7=0/0x20: add=0x0C / sub=0x0D, sll=0x0E, slt=0x0F, sltu=0x10, xor=0x11, srl=0x12 / sra=0x13, or=0x14, and=0x15.
  - `0110011` with funct7=1: mul..remu = 0x1F, 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, indexed by funct3.
  - `0011011` (OP-IMM-32): addiw=0x16, slliw=0x17, srliw=0x18 / sraiw=0x19.
  - `0111011` (OP-32): addw=0x1A / subw=0x1B, sllw=0x1C, srlw=0x1D / sraw=0x1E. With funct7=1: mulw=0x27, divw=0x28, divuw=0x29, remw=0x2A, remuw=0x2B.
- I-type immediate: instr[31:20] sign-extended to BUS_DATA_WIDTH.
- 64-bit shifts use shamt instr[25:20] and zero-extend it into dataB.
- W shifts use instr[24:20]. W shifts with instr[25]=1 are illegal.
- Register x0 always reads 0. Writes to x0 are ignored.
- Scoreboard: 32 busy bits.
  - Set for `rd` when a legal instruction with rd≠0 is accepted.
  - Cleared on `wb_en` for `wb_rd`.
  - If set and clear target the same register in the same cycle, set wins.
- Hazard: rs1 busy, rs2 busy (R-type only), or rd busy (WAW). On a hazard, `in_ready`=0.
- `in_ready` = !hazard && (!out_valid || out_ready). It depends combinationally on `in_instr`.
- Illegal instructions are accepted and issued with `out_illegal`=1 and `alu_control`=0. They do not touch the scoreboard.

## Timing
- Latency: an instruction accepted at edge N appears on the outputs after edge N. `out_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle when there are no hazards and `out_ready`=1.
- While `out_valid` && !`out_ready`, all outputs hold stable.
- `out_valid` falls after a consuming edge with no new accept.
- Register file write occurs at the edge where `wb_en`=1.
- Reset state:
  - `out_valid`=0, `dataA`=`dataB`=0, `alu_control`=0, `out_rd`=0, `out_illegal`=0.
  - All busy bits are cleared and all registers are 0.
  - Reset mid-stall discards the pending instruction.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A `wb_en` write in the same cycle as operand read forwards `wb_data` to the operand.
  - The same-cycle busy clear removes the hazard, so the dependent instruction is accepted in the writeback cycle.
- Undefined:
  - No forwarding. The busy clear takes effect only after the write edge.
  - A dependent instruction is accepted one cycle after the writeback cycle.

## Test plan
- Reset, then issue `addi x1,x0,-5` with out_ready=1 -> next cycle: alu_control=0x01, dataA=0, dataB=0xFFFF_FFFF_FFFF_FFFB, out_rd=1, and x1 is busy.
- `add x3,x1,x2` while x1 busy -> in_ready=0. Then wb_en x1=7: with bypass, accepted that cycle with dataA=7; without bypass, accepted one cycle later.
- `srai x4,x5,63` -> alu_control=0x09, dataB=63. `sraiw` with instr[25]=1 -> out_illegal=1, alu_control=0.
- `mulhu x6,x7,x8` -> 0x22. `remuw` -> 0x2B. Opcode `1111111` -> out_illegal=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Release -> next instruction issued one cycle later.
- Assert reset_n=0 mid-stall -> out_valid=0 asynchronously, scoreboard clear, and x1 reads 0 after reset.

Source files
------------

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_issue
//  Brief    : RV64IM arithmetic decode and operand-issue stage feeding the ALU.
//             Decodes the instruction, reads a 32x64 register file, checks a
//             per-register busy scoreboard and issues through one output
//             pipeline register under valid/ready flow control.
//  Options  : DECODE_BYPASS_EN - forward same-cycle writeback data to the
//             operands and let the same-cycle busy clear lift the hazard.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_issue #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BUS_DATA_WIDTH-1:0] dataA,
    output logic [BUS_DATA_WIDTH-1:0] dataB,
    output logic [5:0]                alu_control,
    output logic [4:0]                out_rd,
    output logic                      out_illegal,
    input  logic                      wb_en,
    input  logic [4:0]                wb_rd,
    input  logic [BUS_DATA_WIDTH-1:0] wb_data
);
    localparam logic [6:0] C_OP_IMM   = 7'b0010011;
    localparam logic [6:0] C_OP       = 7'b0110011;
    localparam logic [6:0] C_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] C_OP32     = 7'b0111011;

    logic [BUS_DATA_WIDTH-1:0] r_regs [32];
    logic [31:0]               r_busy;
    logic                      r_outValid;
    logic [BUS_DATA_WIDTH-1:0] r_dataA;
    logic [BUS_DATA_WIDTH-1:0] r_dataB;
    logic [5:0]                r_aluCtl;
    logic [4:0]                r_outRd;
    logic                      r_outIllegal;

    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_f3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_f7;
    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_f3     = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_f7     = in_instr[31:25];

    logic       w_legal;
    logic [5:0] w_alu;
    logic       w_useRs2;
    logic       w_useShamt6;
    logic       w_useShamt5;

    // Decode opcode/funct fields into an ALU code and operand-B source
    always_comb begin
        w_legal     = 1'b0;
        w_alu       = 6'd0;
        w_useRs2    = 1'b0;
        w_useShamt6 = 1'b0;
        w_useShamt5 = 1'b0;
        case (w_opcode)
            C_OP_IMM: begin
                w_legal = 1'b1;
                case (w_f3)
                    3'd0: w_alu = 6'h01;
                    3'd1: begin w_alu = 6'h07; w_useShamt6 = 1'b1; end
                    3'd2: w_alu = 6'h02;
                    3'd3: w_alu = 6'h03;
                    3'd4: w_alu = 6'h04;
                    3'd5: begin w_alu = in_instr[30] ? 6'h09 : 6'h08; w_useShamt6 = 1'b1; end
                    3'd6: w_alu = 6'h05;
                    default: w_alu = 6'h06;
                endcase
            end
            C_OP: begin
                w_useRs2 = 1'b1;
                if (w_f7 == 7'h01) begin
                    w_legal = 1'b1;
                    w_alu   = 6'h1F + {3'b000, w_f3};
                end else if (w_f7 == 7'h00 || w_f7 == 7'h20) begin
                    case (w_f3)
                        3'd0: begin w_legal = 1'b1; w_alu = w_f7[5] ? 6'h0D : 6'h0C; end
                        3'd5: begin w_legal = 1'b1; w_alu = w_f7[5] ? 6'h13 : 6'h12; end
                        3'd1: begin w_legal = !w_f7[5]; w_alu = 6'h0E; end
                        3'd2: begin w_legal = !w_f7[5]; w_alu = 6'h0F; end
                        3'd3: begin w_legal = !w_f7[5]; w_alu = 6'h10; end
                        3'd4: begin w_legal = !w_f7[5]; w_alu = 6'h11; end
                        3'd6: begin w_legal = !w_f7[5]; w_alu = 6'h14; end
                        default: begin w_legal = !w_f7[5]; w_alu = 6'h15; end
                    endcase
                end
            end
            C_OP_IMM32: begin
                case (w_f3)
                    3'd0: begin w_legal = 1'b1; w_alu = 6'h16; end
                    // W shifts only have a 5-bit shamt; bit 25 set is not encodable
                    3'd1: begin w_legal = !in_instr[25]; w_alu = 6'h17; w_useShamt5 = 1'b1; end
                    3'd5: begin
                        w_legal     = !in_instr[25];
                        w_alu       = in_instr[30] ? 6'h19 : 6'h18;
                        w_useShamt5 = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            C_OP32: begin
                w_useRs2 = 1'b1;
                if (w_f7 == 7'h01) begin
                    case (w_f3)
                        3'd0: begin w_legal = 1'b1; w_alu = 6'h27; end
                        3'd4: begin w_legal = 1'b1; w_alu = 6'h28; end
                        3'd5: begin w_legal = 1'b1; w_alu = 6'h29; end
                        3'd6: begin w_legal = 1'b1; w_alu = 6'h2A; end
                        3'd7: begin w_legal = 1'b1; w_alu = 6'h2B; end
                        default: w_legal = 1'b0;
                    endcase
                end else if (w_f7 == 7'h00 || w_f7 == 7'h20) begin
                    case (w_f3)
                        3'd0: begin w_legal = 1'b1; w_alu = w_f7[5] ? 6'h1B : 6'h1A; end
                        3'd1: begin w_legal = !w_f7[5]; w_alu = 6'h1C; end
                        3'd5: begin w_legal = 1'b1; w_alu = w_f7[5] ? 6'h1E : 6'h1D; end
                        default: w_legal = 1'b0;
                    endcase
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Writeback clear mask; also the hazard view of the scoreboard when bypassing
    logic [31:0] w_wbClr;
    logic [31:0] w_busyView;
    assign w_wbClr = wb_en ? (32'd1 << wb_rd) : 32'd0;

    logic [BUS_DATA_WIDTH-1:0] w_rs1Val;
    logic [BUS_DATA_WIDTH-1:0] w_rs2Val;

`ifdef DECODE_BYPASS_EN
    assign w_busyView = r_busy & ~w_wbClr;

    // Register read with same-cycle writeback forwarding; x0 is hardwired to 0
    always_comb begin
        w_rs1Val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
        w_rs2Val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
        if (wb_en && wb_rd == w_rs1 && w_rs1 != 5'd0) w_rs1Val = wb_data;
        if (wb_en && wb_rd == w_rs2 && w_rs2 != 5'd0) w_rs2Val = wb_data;
    end
`else
    assign w_busyView = r_busy;

    // Register read; x0 is hardwired to 0
    always_comb begin
        w_rs1Val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
        w_rs2Val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    end
`endif

    // Illegal words carry no real operands, so they never wait on the scoreboard
    logic w_hazard;
    logic w_accept;
    assign w_hazard = w_legal && (w_busyView[w_rs1] ||
                                  (w_useRs2 && w_busyView[w_rs2]) ||
                                  w_busyView[w_rd]);
    assign in_ready = !w_hazard && (!r_outValid || out_ready);
    assign w_accept = in_valid && in_ready;

    logic [31:0] w_busySet;
    assign w_busySet = (w_accept && w_legal && w_rd != 5'd0) ? (32'd1 << w_rd) : 32'd0;

    logic [BUS_DATA_WIDTH-1:0] w_opB;
    assign w_opB = w_useRs2    ? w_rs2Val :
                   w_useShamt6 ? {{(BUS_DATA_WIDTH-6){1'b0}}, in_instr[25:20]} :
                   w_useShamt5 ? {{(BUS_DATA_WIDTH-5){1'b0}}, in_instr[24:20]} :
                                 {{(BUS_DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};

    // Register file: written at the writeback edge, writes to x0 dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Busy scoreboard: writeback clears, an accepted issue sets (set wins)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_busy <= '0;
        else          r_busy <= (r_busy & ~w_wbClr) | w_busySet;
    end

    // Output pipeline register: load on accept, hold while stalled, drop on consume
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outValid   <= 1'b0;
            r_dataA      <= '0;
            r_dataB      <= '0;
            r_aluCtl     <= 6'd0;
            r_outRd      <= 5'd0;
            r_outIllegal <= 1'b0;
        end else if (w_accept) begin
            r_outValid   <= 1'b1;
            r_dataA      <= w_rs1Val;
            r_dataB      <= w_opB;
            r_aluCtl     <= w_legal ? w_alu : 6'd0;
            r_outRd      <= w_rd;
            r_outIllegal <= !w_legal;
        end else if (out_ready) begin
            r_outValid   <= 1'b0;
        end
    end

    assign out_valid   = r_outValid;
    assign dataA       = r_dataA;
    assign dataB       = r_dataB;
    assign alu_control = r_aluCtl;
    assign out_rd      = r_outRd;
    assign out_illegal = r_outIllegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_issue
//  Brief    : Self-checking bench for decode_issue using an expected-output
//             queue filled at accept time and drained as the ALU consumes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dataA;
    logic [63:0] dataB;
    logic [5:0]  alu_control;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    typedef struct {
        logic [5:0]  alu;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        ill;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon;
    logic [63:0] mRegs [32];
    int          errors = 0;
    int          checks = 0;

    decode_issue #(.BUS_DATA_WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .dataA(dataA), .dataB(dataB), .alu_control(alu_control),
        .out_rd(out_rd), .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    // Pop the expected entry whenever the ALU consumes an output
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got alu=%h rd=%0d expected no output", alu_control, out_rd);
            end else begin
                mon = sb.pop_front();
                if (alu_control !== mon.alu) begin
                    errors++;
                    $display("FAIL out_alu got=%h exp=%h", alu_control, mon.alu);
                end
                checks++;
                if (out_illegal !== mon.ill) begin
                    errors++;
                    $display("FAIL out_illegal got=%b exp=%b", out_illegal, mon.ill);
                end
                if (mon.chk) begin
                    checks++;
                    if (dataA !== mon.a) begin
                        errors++;
                        $display("FAIL out_dataA got=%h exp=%h", dataA, mon.a);
                    end
                    checks++;
                    if (dataB !== mon.b) begin
                        errors++;
                        $display("FAIL out_dataB got=%h exp=%h", dataB, mon.b);
                    end
                    checks++;
                    if (out_rd !== mon.rd) begin
                        errors++;
                        $display("FAIL out_rd got=%0d exp=%0d", out_rd, mon.rd);
                    end
                end
            end
        end
    end

    // Drive one instruction until accepted; starts and ends just after a rising edge
    task automatic issue(input logic [31:0] instr, input logic [5:0] alu, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic ill,
                         input bit chk, output int waits);
        exp_t e;
        bit   done;
        done     = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.alu = alu; e.a = a; e.b = b; e.rd = rd; e.ill = ill; e.chk = chk;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout instr=%h got no accept exp accept", instr);
        end
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [63:0] d);
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
        @(posedge clk);
        if (rd != 5'd0) mRegs[rd] = d;
        #1 wb_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (dataA !== 64'd0) begin errors++; $display("FAIL rst_dataA got=%h exp=0", dataA); end
        checks++; if (dataB !== 64'd0) begin errors++; $display("FAIL rst_dataB got=%h exp=0", dataB); end
        checks++; if (alu_control !== 6'd0) begin errors++; $display("FAIL rst_alu got=%h exp=0", alu_control); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0d exp=0", out_rd); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%b exp=0", out_illegal); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        int w;
        issue(iType(12'hFFB, 5'd0, 3'd0, 5'd1, 7'h13), 6'h01, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 5'd1, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL addi_wait got=%0d exp=0", w); end
    endtask

    task automatic test_hazard();
        exp_t e;
        in_valid = 1'b1;
        in_instr = rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
        repeat (2) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_raw got=%b exp=0", in_ready); end
            @(posedge clk); #1;
        end
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd7;
        e.alu = 6'h0C; e.a = 64'd7; e.b = 64'd0; e.rd = 5'd3; e.ill = 1'b0; e.chk = 1'b1;
        @(negedge clk);
`ifdef DECODE_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got=%b exp=1", in_ready); end
        sb.push_back(e);
        @(posedge clk); mRegs[1] = 64'd7;
        #1 wb_en = 1'b0; in_valid = 1'b0;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wb_cycle_ready got=%b exp=0", in_ready); end
        @(posedge clk); mRegs[1] = 64'd7;
        #1 wb_en = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_wb_ready got=%b exp=1", in_ready); end
        sb.push_back(e);
        @(posedge clk); #1 in_valid = 1'b0;
`endif
        // x3 is now busy: a second writer to x3 must wait
        in_valid = 1'b1;
        in_instr = iType(12'd1, 5'd0, 3'd0, 5'd3, 7'h13);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_waw got=%b exp=0", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        writeback(5'd3, 64'h33);
    endtask

    task automatic test_shifts();
        int w;
        writeback(5'd5, 64'h8000_0000_0000_1234);
        writeback(5'd7, 64'd1000);
        writeback(5'd8, 64'hFFFF_FFFF_FFFF_FFF0);
        issue(iType({6'b010000, 6'd63}, 5'd5, 3'd5, 5'd4, 7'h13), 6'h09, mRegs[5], 64'd63, 5'd4, 1'b0, 1'b1, w);
        issue(iType(12'd33, 5'd5, 3'd1, 5'd12, 7'h13), 6'h07, mRegs[5], 64'd33, 5'd12, 1'b0, 1'b1, w);
        issue(iType(12'h425, 5'd5, 3'd5, 5'd9, 7'h1B), 6'h00, 64'd0, 64'd0, 5'd9, 1'b1, 1'b0, w);
        issue(iType(12'h405, 5'd5, 3'd5, 5'd16, 7'h1B), 6'h19, mRegs[5], 64'd5, 5'd16, 1'b0, 1'b1, w);
        // The illegal sraiw above must not have marked x9 busy
        issue(iType(12'h7FF, 5'd0, 3'd0, 5'd9, 7'h13), 6'h01, 64'd0, 64'h7FF, 5'd9, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL illegal_no_busy waits got=%0d exp=0", w); end
    endtask

    task automatic test_muldiv();
        int w;
        issue(rType(7'h01, 5'd8, 5'd7, 3'd3, 5'd6, 7'h33), 6'h22, mRegs[7], mRegs[8], 5'd6, 1'b0, 1'b1, w);
        issue(rType(7'h01, 5'd8, 5'd7, 3'd7, 5'd10, 7'h3B), 6'h2B, mRegs[7], mRegs[8], 5'd10, 1'b0, 1'b1, w);
        issue(rType(7'h20, 5'd8, 5'd7, 3'd0, 5'd11, 7'h33), 6'h0D, mRegs[7], mRegs[8], 5'd11, 1'b0, 1'b1, w);
        issue(32'h0000_007F, 6'h00, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        issue(iType(12'd1, 5'd5, 3'd0, 5'd17, 7'h13), 6'h01, mRegs[5], 64'd1, 5'd17, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_0 waits got=%0d exp=0", w); end
        issue(iType(12'hFFF, 5'd7, 3'd4, 5'd18, 7'h13), 6'h04, mRegs[7], {64{1'b1}}, 5'd18, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_1 waits got=%0d exp=0", w); end
        issue(rType(7'h00, 5'd8, 5'd7, 3'd7, 5'd19, 7'h33), 6'h15, mRegs[7], mRegs[8], 5'd19, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL b2b_2 waits got=%0d exp=0", w); end
    endtask

    task automatic test_stall();
        int   w;
        exp_t e;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(iType(12'h0F0, 5'd7, 3'd6, 5'd20, 7'h13), 6'h05, mRegs[7], 64'hF0, 5'd20, 1'b0, 1'b1, w);
        in_valid = 1'b1;
        in_instr = iType(12'h00F, 5'd8, 3'd7, 5'd21, 7'h13);
        repeat (3) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
            checks++; if (alu_control !== 6'h05) begin errors++; $display("FAIL stall_alu got=%h exp=05", alu_control); end
            checks++; if (dataA !== mRegs[7]) begin errors++; $display("FAIL stall_dataA got=%h exp=%h", dataA, mRegs[7]); end
            checks++; if (dataB !== 64'hF0) begin errors++; $display("FAIL stall_dataB got=%h exp=f0", dataB); end
            checks++; if (out_rd !== 5'd20) begin errors++; $display("FAIL stall_rd got=%0d exp=20", out_rd); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", in_ready); end
        e.alu = 6'h06; e.a = mRegs[8]; e.b = 64'hF; e.rd = 5'd21; e.ill = 1'b0; e.chk = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL valid_falls got=%b exp=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstall();
        int w;
        out_ready = 1'b0;
        issue(iType(12'd1, 5'd1, 3'd0, 5'd13, 7'h13), 6'h01, mRegs[1], 64'd1, 5'd13, 1'b0, 1'b1, w);
        in_valid = 1'b1;
        in_instr = iType(12'd2, 5'd0, 3'd0, 5'd22, 7'h13);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
        sb.delete();
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        issue(iType(12'd0, 5'd13, 3'd0, 5'd14, 7'h13), 6'h01, 64'd0, 64'd0, 5'd14, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL reset_busy_clear waits got=%0d exp=0", w); end
        issue(rType(7'h00, 5'd0, 5'd1, 3'd0, 5'd15, 7'h33), 6'h0C, 64'd0, 64'd0, 5'd15, 1'b0, 1'b1, w);
        checks++; if (w != 0) begin errors++; $display("FAIL reset_x1_waits got=%0d exp=0", w); end
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drained got=%0d exp=0", sb.size()); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_hazard();
        test_shifts();
        test_muldiv();
        test_back_to_back();
        test_stall();
        test_reset_midstall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
